// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer for the A/B accumulator CPU: owns pc and IR,
// handshakes with instruction memory, and issues the one-cycle execute strobe.
module pc_sequencer #(
  parameter int ADDR_W = 8,
  parameter int LIT_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 im_req,
  output logic [ADDR_W-1:0]    im_addr,
  input  logic                 im_ack,
  input  logic [7+LIT_W-1:0]   im_data,
  input  logic [3:0]           status,
  output logic [6:0]           opcode,
  output logic [LIT_W-1:0]     literal,
  output logic                 ex_en,
  output logic [ADDR_W-1:0]    pc,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALTED} state_t;

  typedef struct packed {
    logic [6:0]       op;
    logic [LIT_W-1:0] lit;
  } ir_t;

  state_t state, state_nxt;
  ir_t    ir;
  logic   is_jump, taken, is_halt;

  assign opcode  = ir.op;
  assign literal = ir.lit;
  assign im_addr = pc;
  assign is_halt = (ir.op == 7'h7F);

  // Flags: [0]=Z [1]=N [2]=C [3]=V, sampled live during EXEC.
  always_comb begin
    is_jump = 1'b1;
    taken   = 1'b0;
    case (ir.op)
      7'h50:   taken = 1'b1;
      7'h51:   taken = status[0];
      7'h52:   taken = !status[0];
      7'h53:   taken = !status[0] && !status[1];
      7'h54:   taken = status[1];
      7'h55:   taken = !status[1];
      7'h56:   taken = status[0] || status[1];
      7'h57:   taken = status[2];
      7'h58:   taken = status[3];
      default: is_jump = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = FETCH;
      FETCH:   if (im_ack) state_nxt = DECODE;
      DECODE:  state_nxt = EXEC;
      EXEC:    state_nxt = is_halt ? HALTED : FETCH;
      HALTED:  if (start)  state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by rst so a reset landing in EXEC never leaks a write strobe.
  always_comb begin
    im_req = (state == FETCH) && !rst;
    ex_en  = (state == EXEC) && !is_jump && !is_halt && !rst;
    busy   = (state == FETCH) || (state == DECODE) || (state == EXEC);
    halted = (state == HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      case (state)
        FETCH: if (im_ack) ir <= im_data;
        EXEC: begin
          if (retired != '1) retired <= retired + CNT_W'(1);
          if (is_jump && taken) pc <= ADDR_W'(ir.lit);
          else if (!is_halt)    pc <= pc + ADDR_W'(1);
        end
        HALTED: if (start) begin
          pc      <= '0;
          retired <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + randomized bench for pc_sequencer against an instruction-level model.
module tb_pc_sequencer;
  localparam int AW = 8, LW = 8, CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, im_req, im_ack, ex_en, busy, halted;
  logic [AW-1:0] im_addr, pc;
  logic [6+LW:0] im_data;
  logic [3:0]    status;
  logic [6:0]    opcode;
  logic [LW-1:0] literal;
  logic [CW-1:0] retired;

  int n_cmp = 0, n_err = 0;
  int m_pc = 0, m_ret = 0;
  bit m_halt = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(AW), .LIT_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .im_req(im_req), .im_addr(im_addr),
    .im_ack(im_ack), .im_data(im_data), .status(status), .opcode(opcode),
    .literal(literal), .ex_en(ex_en), .pc(pc), .busy(busy), .halted(halted),
    .retired(retired)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Branch conditions straight from the flag table; f = {V,C,N,Z}.
  function automatic bit ref_taken(input logic [6:0] op, input logic [3:0] f);
    bit z, n, c, v;
    {v, c, n, z} = f;
    case (op)
      7'h50: return 1'b1;
      7'h51: return z;
      7'h52: return !z;
      7'h53: return !z && !n;
      7'h54: return n;
      7'h55: return !n;
      7'h56: return z || n;
      7'h57: return c;
      7'h58: return v;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_req"}, 32'(im_req), 0);
    chk({tag, "_pc"}, 32'(pc), 0);
    chk({tag, "_op"}, 32'(opcode), 0);
    chk({tag, "_lit"}, 32'(literal), 0);
    chk({tag, "_ex"}, 32'(ex_en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_halt"}, 32'(halted), 0);
    chk({tag, "_ret"}, 32'(retired), 0);
  endtask

  // Entered with the DUT in FETCH; leaves it one cycle after EXEC.
  task automatic run_instr(input logic [6:0] op, input logic [7:0] lit,
                           input int waits, input logic [3:0] st);
    logic [6:0] prev_op;
    bit jmp, hlt;
    prev_op = opcode;
    chk("fetch_req", 32'(im_req), 1);
    chk("fetch_addr", 32'(im_addr), 32'(m_pc));
    chk("fetch_ex", 32'(ex_en), 0);
    for (int w = 0; w < waits; w++) begin
      im_ack  = 1'b0;
      im_data = 15'($urandom);
      tick;
      chk("wait_req", 32'(im_req), 1);
      chk("wait_addr", 32'(im_addr), 32'(m_pc));
      chk("ir_hold", 32'(opcode), 32'(prev_op));
    end
    im_ack  = 1'b1;
    im_data = {op, lit};
    tick;
    // Stray acks outside FETCH must not disturb IR.
    im_ack  = 1'($urandom_range(0, 1));
    im_data = 15'($urandom);
    chk("dec_op", 32'(opcode), 32'(op));
    chk("dec_lit", 32'(literal), 32'(lit));
    chk("dec_ex", 32'(ex_en), 0);
    chk("dec_req", 32'(im_req), 0);
    status = st;
    tick;
    jmp = (op >= 7'h50) && (op <= 7'h58);
    hlt = (op == 7'h7F);
    chk("exec_ex", 32'(ex_en), 32'(!jmp && !hlt));
    chk("exec_op", 32'(opcode), 32'(op));
    if (jmp && ref_taken(op, st)) m_pc = int'(lit);
    else if (!hlt)                m_pc = (m_pc + 1) % 256;
    if (m_ret < 65535) m_ret++;
    m_halt = hlt;
    tick;
    im_ack = 1'b0;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("retired", 32'(retired), 32'(m_ret));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("busy", 32'(busy), 32'(!m_halt));
  endtask

  task automatic restart;
    start = 1'b1;
    tick;
    start = 1'b0;
    m_pc = 0; m_ret = 0; m_halt = 1'b0;
    chk("restart_pc", 32'(pc), 0);
    chk("restart_ret", 32'(retired), 0);
    chk("restart_req", 32'(im_req), 1);
  endtask

  initial begin
    logic [6:0] op;
    rst = 1'b1; start = 1'b0; im_ack = 1'b0; im_data = '0; status = '0;
    tick; tick;
    rst = 1'b0;
    tick;
    check_reset("por");

    // Reset in the middle of an unacknowledged fetch.
    start = 1'b1; tick; start = 1'b0;
    chk("pre_rst_req", 32'(im_req), 1);
    tick;
    rst = 1'b1; tick; tick; rst = 1'b0;
    check_reset("midfetch");
    tick;
    chk("idle_req", 32'(im_req), 0);

    // Straight-line program ending in HALT.
    start = 1'b1; tick; start = 1'b0;
    run_instr(7'h02, 8'h05, 0, 4'($urandom));
    run_instr(7'h06, 8'h03, 0, 4'($urandom));
    run_instr(7'h7F, 8'h00, 0, 4'($urandom));
    chk("sl_pc", 32'(pc), 2);
    chk("sl_ret", 32'(retired), 3);
    tick;
    chk("halt_stays", 32'(halted), 1);

    restart;
    // start held high while busy must be ignored.
    start = 1'b1;
    run_instr(7'h51, 8'h10, 0, 4'b0001);
    run_instr(7'h51, 8'h20, 0, 4'b0000);
    run_instr(7'h53, 8'h30, 0, 4'b0010);
    run_instr(7'h06, 8'h01, 4, 4'($urandom));
    run_instr(7'h50, 8'hFF, 1, 4'($urandom));
    run_instr(7'h07, 8'h00, 0, 4'($urandom));
    chk("wrap_addr", 32'(im_addr), 0);

    for (int i = 0; i < 40; i++) begin
      start = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) op = 7'(7'h50 + $urandom_range(0, 8));
      else                           op = 7'($urandom_range(0, 126));
      run_instr(op, 8'($urandom), int'($urandom_range(0, 3)), 4'($urandom));
    end
    start = 1'b0;
    run_instr(7'h7F, 8'($urandom), 2, 4'($urandom));

    // Reset arriving during EXEC of a data instruction.
    restart;
    im_ack = 1'b1; im_data = {7'h06, 8'h11}; tick; im_ack = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    chk("rst_exec_ex", 32'(ex_en), 0);
    tick;
    rst = 1'b0;
    check_reset("rst_exec");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle fetch/decode/execute sequencer for the A/B accumulator CPU. Owns the program counter and the instruction register, and handshakes with instruction memory. Presents the registered opcode and literal to the combinational control decoder. Generates the single-cycle execute strobe that gates LA/LB/mem_we, and resolves jump and halt opcodes against the ALU status flags.

Parameters:
ADDR_W, 8, program counter / instruction memory address width
LIT_W, 8, literal (K) field width; instruction word = {opcode[6:0], literal[LIT_W-1:0]}
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin execution; honoured only in IDLE or HALTED
im_req  out  1  instruction fetch request
im_addr  out  ADDR_W  fetch address (= pc)
im_ack  in  1  fetch data valid; qualified by im_req
im_data  in  7+LIT_W  fetched instruction word
status  in  4  ALU flags: [0]=Z, [1]=N, [2]=C, [3]=V
opcode  out  7  registered IR opcode field, to control decoder
literal  out  LIT_W  registered IR literal (K)
ex_en  out  1  execute strobe; datapath register/memory writes are ANDed with it
pc  out  ADDR_W  current program counter
busy  out  1  high in FETCH, DECODE, EXEC
halted  out  1  high in HALTED
retired  out  CNT_W  retired-instruction count, saturating

Behaviour:
- One clock (clk); rst is synchronous, active-high. All state updates occur on the rising edge of clk.
- Reset values: state=IDLE, pc=0, IR=0 (opcode=0, literal=0), im_req=0, ex_en=0, busy=0, halted=0, retired=0. rst has priority over all other inputs in any state, including mid-fetch and during EXEC; no write strobe is issued in the reset cycle.
- States: IDLE, FETCH, DECODE, EXEC, HALTED.
- IDLE
  - start=1 -> FETCH; pc is not changed.
- FETCH
  - im_req=1, im_addr=pc.
  - im_ack=1 -> IR<=im_data, then DECODE. Zero-wait ack in the same cycle as im_req is legal.
  - Otherwise stay in FETCH, holding im_req and im_addr stable.
  - im_ack in any other state is ignored.
- DECODE
  - One cycle so that decoder outputs and status settle; ex_en=0.
  - Always -> EXEC.
- EXEC (exactly one cycle; always increments retired unless it is at max):
  - Jump opcodes: ex_en=0; pc<=literal[ADDR_W-1:0] if taken, else pc+1; -> FETCH. Jump set:
    - JMP 7'h50 always
    - JEQ 7'h51 Z
    - JNE 7'h52 !Z
    - JGT 7'h53 !Z&!N
    - JLT 7'h54 N
    - JGE 7'h55 !N
    - JLE 7'h56 Z|N
    - JCR 7'h57 C
    - JOV 7'h58 V
  - HALT 7'h7F: ex_en=0; pc unchanged; -> HALTED.
  - All other opcodes (including undefined): ex_en=1; pc<=pc+1; -> FETCH.
  - status is sampled combinationally during EXEC. It reflects flags written by the most recent ex_en cycle.
- HALTED
  - halted=1.
  - start=1 -> pc<=0, retired<=0, -> FETCH.
- start outside IDLE and HALTED is ignored.
- pc arithmetic is modulo 2^ADDR_W: pc=2^ADDR_W-1 with a non-jump instruction wraps to 0 with no flag.
- retired saturates at 2^CNT_W-1.
- Throughput: 3 cycles per instruction with zero-wait memory, plus 1 cycle per im_ack wait cycle.
- opcode/literal outputs change only on the FETCH->DECODE edge; they are held stable through DECODE and EXEC.

Test Plan:
- Reset: assert rst 2 cycles mid-FETCH with im_ack=0 -> all outputs at reset values, state IDLE, im_req=0 the cycle after rst falls.
- Straight line: program MOV A,K 5 (7'h02,05); ADD A,K 3 (7'h06,03); HALT; start pulse, zero-wait ack -> ex_en high exactly on cycles 3 and 6 after FETCH entry, halted=1 with pc=2, retired=3.
- Branch: JEQ 0x10 with Z=1 -> pc=0x10 after EXEC, ex_en stays 0. Same with Z=0 -> pc=prev+1. JGT with Z=0, N=1 -> not taken.
- Wait states: im_ack delayed 4 cycles -> im_req and im_addr held constant for 5 cycles, IR unchanged until ack, then one instruction completes.
- Wrap: pc=0xFF holding ADD A,B -> next FETCH im_addr=0x00.
- Halt/restart: start asserted while busy -> ignored. start in HALTED -> pc=0, retired=0, FETCH next cycle.
